// File: rtl/bus_grant.sv
// bus_grant: registered round-robin grant generator feeding the bus mux gate.
//
// The design locks the grant onto the current requester for its whole burst.
// When HOLD_MAX is non-zero, the grant is released after HOLD_MAX consecutive
// cycles if another port is waiting. A new winner is chosen by a round-robin
// search. The search starts at the pointer and moves in ascending order,
// wrapping around from the top port back to port 0.
//
// Ports:
//   clk          system clock, every register updates on its rising edge
//   rst          synchronous reset, active high; it overrides every other input
//   request      bit i high means port i wants the bus (held for the whole burst)
//   grant        registered gate vector for the mux: either zero or one-hot
//   grant_index  binary index of the set grant bit, 0 when nothing is granted
//   grant_valid  high whenever a grant bit is set
module bus_grant #(
    parameter int DATA_NUM    = 4,
    parameter int HOLD_MAX    = 0,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_NUM-1:0]    request,
    output logic [DATA_NUM-1:0]    grant,
    output logic [INDEX_WIDTH-1:0] grant_index,
    output logic                   grant_valid
);

    // The counter only has to hold values up to HOLD_MAX. When HOLD_MAX is 0
    // the counter is never used, so a single bit is kept to give it a legal width.
    localparam int                   CNT_W      = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]     HOLD_LIM   = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
    localparam logic [INDEX_WIDTH:0] PORT_COUNT = (INDEX_WIDTH + 1)'(DATA_NUM);
    localparam bit                   TIMEOUT_EN = (HOLD_MAX > 0);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                 state_q;
    logic [DATA_NUM-1:0]    grant_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic                   valid_q;
    logic [INDEX_WIDTH-1:0] ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    // The current holder is masked out of the search. On release its request
    // bit is already low, so the mask has no effect. On timeout the mask makes
    // the search look only at the other ports. In IDLE grant_q is zero, so every
    // request is searched.
    logic [DATA_NUM-1:0]    search_req;
    logic [INDEX_WIDTH-1:0] cand_idx [DATA_NUM];
    logic [DATA_NUM-1:0]    cand_hit;
    logic [DATA_NUM-1:0]    win_onehot_d;
    logic [INDEX_WIDTH-1:0] win_idx_d;
    logic                   win_found;
    logic [INDEX_WIDTH:0]   ptr_inc;
    logic [INDEX_WIDTH-1:0] ptr_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   held;
    logic                   timeout;
    logic                   do_load;

    assign search_req = request & ~grant_q;

    // Candidate gi is the port at offset gi from the pointer, taken modulo DATA_NUM.
    for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_cand
        logic [INDEX_WIDTH:0] sum;
        assign sum          = {1'b0, ptr_q} + (INDEX_WIDTH + 1)'(gi);
        assign cand_idx[gi] = (sum >= PORT_COUNT) ? INDEX_WIDTH'(sum - PORT_COUNT)
                                                  : sum[INDEX_WIDTH-1:0];
        assign cand_hit[gi] = search_req[cand_idx[gi]];
    end

    // Scan from the highest offset down to the lowest. The lowest offset that
    // has a request is written last, so it is the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx_d = '0;
        for (int i = DATA_NUM - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win_found = 1'b1;
                win_idx_d = cand_idx[i];
            end
        end
    end

    for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_onehot
        assign win_onehot_d[gi] = (win_idx_d == INDEX_WIDTH'(gi));
    end

    assign ptr_inc = {1'b0, win_idx_d} + (INDEX_WIDTH + 1)'(1);
    assign ptr_d   = (ptr_inc == PORT_COUNT) ? '0 : ptr_inc[INDEX_WIDTH-1:0];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // held: the current holder is still requesting. If held is low, the holder
    // has released the bus; when release and timeout happen together, release wins.
    assign held    = |(request & grant_q);
    assign timeout = TIMEOUT_EN && held && (cnt_q == HOLD_LIM);
    assign do_load = win_found && (!held || timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (do_load) begin
            // New grant: issued from IDLE, after a release, or as a fairness handover.
            state_q <= S_GRANT;
            grant_q <= win_onehot_d;
            index_q <= win_idx_d;
            valid_q <= 1'b1;
            ptr_q   <= ptr_d;
            cnt_q   <= CNT_W'(1);
        end else if (state_q == S_GRANT) begin
            if (!held) begin
                // The holder released and nobody else is waiting.
                state_q <= S_IDLE;
                grant_q <= '0;
                index_q <= '0;
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end else if (timeout) begin
                // Hold limit reached but no other port is waiting:
                // keep the grant and start a new hold window.
                cnt_q <= CNT_W'(1);
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign grant       = grant_q;
    assign grant_index = index_q;
    assign grant_valid = valid_q;

endmodule

// File: tb/tb_bus_grant.sv
module tb_bus_grant;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] request = 4'b0000;

    logic [3:0] grant0, grant4;
    logic [1:0] gidx0, gidx4;
    logic       gval0, gval4;

    int checks = 0;
    int errors = 0;

    bus_grant #(.DATA_NUM(4), .HOLD_MAX(0), .INDEX_WIDTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .request(request),
        .grant(grant0), .grant_index(gidx0), .grant_valid(gval0)
    );

    bus_grant #(.DATA_NUM(4), .HOLD_MAX(4), .INDEX_WIDTH(2)) u_dut4 (
        .clk(clk), .rst(rst), .request(request),
        .grant(grant4), .grant_index(gidx4), .grant_valid(gval4)
    );

    always #5 clk = ~clk;

    // Packed view {grant, grant_index, grant_valid}; index 0 = HOLD_MAX 0, 1 = HOLD_MAX 4.
    logic [6:0] obs [2];
    assign obs[0] = {grant0, gidx0, gval0};
    assign obs[1] = {grant4, gidx4, gval4};

    // Reference model: granted port number (-1 = none), rotation start, hold length.
    typedef struct packed {
        int g;
        int p;
        int c;
    } mstate_t;

    mstate_t m [2] = '{'{-1, 0, 0}, '{-1, 0, 0}};

    function automatic int rr_pick(logic [3:0] r, int start, int excl);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (start + i) % 4;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    function automatic mstate_t step(mstate_t s, logic [3:0] r, logic rs, int h);
        mstate_t n;
        int w;
        n = s;
        if (rs) begin
            n.g = -1; n.p = 0; n.c = 0;
            return n;
        end
        if (s.g < 0) begin
            w = rr_pick(r, s.p, -1);
        end else if (!r[s.g]) begin
            w = rr_pick(r, s.p, s.g);
            if (w < 0) begin
                n.g = -1; n.c = 0;
                return n;
            end
        end else if (h > 0 && s.c == h) begin
            w = rr_pick(r, s.p, s.g);
            if (w < 0) begin
                n.c = 1;
                return n;
            end
        end else begin
            n.c = s.c + 1;
            return n;
        end
        if (w >= 0) begin
            n.g = w; n.p = (w + 1) % 4; n.c = 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= step(m[0], request, rst, 0);
        m[1] <= step(m[1], request, rst, 4);
    end

    function automatic logic [6:0] exp_vec(int k);
        logic [3:0] gv;
        if (m[k].g < 0) return 7'd0;
        gv = 4'b0001 << m[k].g;
        return {gv, 2'(m[k].g), 1'b1};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        request = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            $display("[%0t] reset req=%b rst=%b g0=%b g4=%b", $time, request, rst, grant0, grant4);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== 7'd0) begin
                    errors++;
                    $display("FAIL reset_outputs u%0d: got %b want 0000000", k, obs[k]);
                end
            end
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[%0t] reset_release req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {4'b0001, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL reset_release u%0d: got %b want 0001001", k, obs[k]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        logic [3:0] want_next;
        for (int p = 0; p < 4; p++) begin
            want = 4'b0001 << p;
            repeat (2) begin
                @(negedge clk);
                $display("[%0t] rotation hold req=%b g0=%b g4=%b", $time, request, grant0, grant4);
                checks++;
                if (grant0 !== want) begin
                    errors++;
                    $display("FAIL rotation_hold: got %b want %b", grant0, want);
                end
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs[k] !== exp_vec(k)) begin
                        errors++;
                        $display("FAIL rotation_model u%0d: got %b want %b", k, obs[k], exp_vec(k));
                    end
                end
            end
            request = 4'b1111 & ~want;
            @(negedge clk);
            want_next = 4'b0001 << ((p + 1) % 4);
            $display("[%0t] rotation handover req=%b g0=%b g4=%b", $time, request, grant0, grant4);
            checks++;
            if (grant0 !== want_next || gval0 !== 1'b1) begin
                errors++;
                $display("FAIL rotation_handover: got %b/%b want %b/1", grant0, gval0, want_next);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL rotation_model u%0d: got %b want %b", k, obs[k], exp_vec(k));
                end
            end
            request = 4'b1111;
        end
    endtask

    task automatic test_burst_lock();
        request = 4'b0000;
        repeat (2) @(negedge clk);
        request = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            $display("[%0t] burst c=%0d req=%b g0=%b g4=%b", $time, c, request, grant0, grant4);
            checks++;
            if (grant0 !== 4'b0100) begin
                errors++;
                $display("FAIL burst_lock c%0d: got %b want 0100", c, grant0);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL burst_model u%0d: got %b want %b", k, obs[k], exp_vec(k));
                end
            end
            if (c == 2) request = 4'b0101;
        end
        request = 4'b0001;
        @(negedge clk);
        $display("[%0t] burst end req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        checks++;
        if (grant0 !== 4'b0001) begin
            errors++;
            $display("FAIL burst_release: got %b want 0001", grant0);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL burst_model u%0d: got %b want %b", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] want;
        rst = 1'b1;
        request = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        request = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            want = (((i / 4) % 2) == 0) ? 4'b0010 : 4'b1000;
            $display("[%0t] timeout i=%0d req=%b g0=%b g4=%b", $time, i, request, grant0, grant4);
            checks++;
            if (grant4 !== want) begin
                errors++;
                $display("FAIL timeout_alternate i%0d: got %b want %b", i, grant4, want);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL timeout_model u%0d: got %b want %b", k, obs[k], exp_vec(k));
                end
            end
        end
        request = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            $display("[%0t] timeout_solo i=%0d req=%b g0=%b g4=%b", $time, i, request, grant0, grant4);
            checks++;
            if (grant4 !== 4'b0010) begin
                errors++;
                $display("FAIL timeout_solo i%0d: got %b want 0010", i, grant4);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL timeout_model u%0d: got %b want %b", k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_release_wrap();
        rst = 1'b1;
        request = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        request = 4'b0100;
        @(negedge clk);
        request = 4'b0000;
        @(negedge clk);
        $display("[%0t] wrap idle req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL wrap_idle u%0d: got %b want 0000000", k, obs[k]);
            end
        end
        request = 4'b0001;
        @(negedge clk);
        $display("[%0t] wrap grant req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {4'b0001, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL wrap_grant u%0d: got %b want 0001001", k, obs[k]);
            end
        end
        request = 4'b0000;
        @(negedge clk);
        $display("[%0t] wrap release req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL wrap_release u%0d: got %b want 0000000", k, obs[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        rst = 1'b1;
        request = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        request = 4'b1000;
        repeat (2) begin
            @(negedge clk);
            $display("[%0t] midrst burst req=%b g0=%b g4=%b", $time, request, grant0, grant4);
            checks++;
            if (grant0 !== 4'b1000 || grant4 !== 4'b1000) begin
                errors++;
                $display("FAIL midrst_burst: got %b/%b want 1000/1000", grant0, grant4);
            end
        end
        request = 4'b1001;
        rst = 1'b1;
        @(negedge clk);
        $display("[%0t] midrst reset req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL midrst_drop u%0d: got %b want 0000000", k, obs[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[%0t] midrst regrant req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {4'b0001, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL midrst_regrant u%0d: got %b want 0001001", k, obs[k]);
            end
        end
        // Grant port 1 so the rotation start moves to 2, then reset. Afterwards
        // port 1 must win again, which shows the rotation start went back to 0.
        request = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        request = 4'b0110;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[%0t] midrst pointer req=%b g0=%b g4=%b", $time, request, grant0, grant4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== {4'b0010, 2'd1, 1'b1}) begin
                errors++;
                $display("FAIL midrst_pointer u%0d: got %b want 0010011", k, obs[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] g;
        logic [3:0] r;
        rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            r = request;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
            end
            request = r;
            rst = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            $display("[%0t] random n=%0d req=%b rst=%b g0=%b g4=%b", $time, n, request, rst, grant0, grant4);
            for (int k = 0; k < 2; k++) begin
                g = obs[k][6:3];
                checks++;
                if (obs[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random_model u%0d n%0d: got %b want %b", k, n, obs[k], exp_vec(k));
                end
                checks++;
                if (!$onehot0(g) || obs[k][0] !== (|g)) begin
                    errors++;
                    $display("FAIL random_invariant u%0d n%0d: got %b want onehot0 grant with valid=|grant", k, n, obs[k]);
                end
                checks++;
                if ((obs[k][0] && g[obs[k][2:1]] !== 1'b1) || (!obs[k][0] && obs[k][2:1] !== 2'd0)) begin
                    errors++;
                    $display("FAIL random_index u%0d n%0d: got %b want index matching grant", k, n, obs[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_burst_lock();
        test_timeout();
        test_release_wrap();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/bus_grant.md
Name: bus_grant

Overview:
- Registered round-robin grant generator that sits directly upstream of the bus multiplexer.
- Takes per-port request lines and produces the one-hot gate vector that selects which port's word is forwarded onto the shared bus.
- Grants are locked for the duration of a requester's burst, bounded by an optional hold limit for fairness.
- Also provides a binary grant index and a valid flag for downstream bookkeeping.

Parameters:
- DATA_NUM, 4, number of requesting ports (>=2); width of request and grant.
- HOLD_MAX, 0, maximum consecutive cycles one port may hold a grant; 0 = unlimited.
- INDEX_WIDTH, 2, width of grant_index; must be >= clog2(DATA_NUM).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active high.
- request  input  DATA_NUM  bit i high = port i wants the bus; held high for the whole burst.
- grant  output  DATA_NUM  one-hot (or zero) registered gate vector; drives the mux gate input.
- grant_index  output  INDEX_WIDTH  binary index of the set grant bit; 0 when grant_valid is low.
- grant_valid  output  1  high when any grant bit is set.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst high at an edge) forces:
  - grant=0, grant_index=0, grant_valid=0
  - hold counter=0
  - round-robin pointer=0
  - state IDLE
- rst overrides all other inputs. Asserting it mid-burst drops the grant on the next edge.
- All outputs are registered. There is no combinational path from request to outputs.
- Latency: a request seen in IDLE produces a grant on the following edge (1 cycle).
- Round-robin search: starting at the pointer, the first index (ascending, wrapping DATA_NUM-1 -> 0) with request high wins.
  - The pointer is set to (winner+1) mod DATA_NUM whenever a new grant is issued.
- State IDLE (grant=0):
  - If any request is high: load the winner into grant and grant_index, set grant_valid=1, set counter=1, go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT (port g granted):
  - Release: request[g] low at the edge. Search the other requests.
    - If any is found, hand over directly with no idle cycle (new one-hot, counter=1).
    - If none, go to IDLE with grant=0.
  - Timeout: HOLD_MAX>0, request[g] high, and counter==HOLD_MAX.
    - If another port requests, hand over to the round-robin winner (counter=1).
    - If no other port requests, keep g and restart counter=1.
  - Otherwise keep grant and increment the counter. The counter saturates and is unused when HOLD_MAX=0.
- Simultaneous events:
  - If release and timeout coincide, release rules apply.
  - A new request arriving in the same cycle as a handover participates in that search.
- The counter width is sized to hold HOLD_MAX; no wrap to 0 while holding.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_index matches the set bit.
- Known and accepted: in the cycle after request[g] falls, grant[g] is still set. The downstream side treats that cycle's data as don't-care.

Test Plan:
- Reset/idle: rst high 2 cycles with request=4'b1111, then rst low.
  - Required: grant=0, grant_index=0, grant_valid=0 during reset.
  - Required: one edge after rst falls, grant=4'b0001, grant_index=0.
- Round-robin rotation (HOLD_MAX=0): request=4'b1111, each port drops its request for one cycle after 3 cycles of grant, then raises it again.
  - Required grant sequence: 0001, 0010, 0100, 1000, 0001, with each handover on the edge after the drop and no zero cycle between.
- Burst lock: port 2 alone requests for 10 cycles while port 0 raises its request at cycle 3.
  - Required: grant=4'b0100 for all 10 cycles, then 4'b0001 on the next edge.
- Timeout fairness (HOLD_MAX=4): ports 1 and 3 hold requests high continuously.
  - Required: grant alternates 0010 x4 cycles, 1000 x4, 0010 x4.
  - Required: with only port 1 requesting, 0010 is held indefinitely with the counter restarting.
- Release to idle and wrap: pointer at 3, request=4'b0001 pulse then all low.
  - Required: grant=4'b0001 (wrap 3->0), then grant=0 and grant_valid=0 one edge after request falls.
- Reset mid-burst: grant=4'b1000 active, rst high for 1 cycle with requests held.
  - Required: grant=0 after that edge, pointer=0, then grant=4'b0001 (if port 0 requests) one edge after rst falls.
